// File: rtl/drvr_fifo_pkg.sv
// Shared types and width helpers for the driver FIFO bank.
// Every channel sizes its pointers and occupancy counter from these helpers.
package drvr_fifo_pkg;

  typedef enum logic {OVF_DROP = 1'b0, OVF_OVERWRITE = 1'b1} ovf_mode_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/drvr_fifo_chnl.sv
// Single first-word-fall-through channel. The head entry comes from a mux of
// registered storage and pointer, so no input has a combinational path to any output.
module drvr_fifo_chnl
  import drvr_fifo_pkg::*;
#(
  parameter int PCKG  = 16,
  parameter int DEPTH = 8,
  parameter int MODE  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [PCKG-1:0]           D_push,
  input  logic                      pop,
  input  logic                      err_clr,
  output logic [PCKG-1:0]           D_pop,
  output logic                      pndng,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      ovf,
  output logic                      udf
);

  localparam int             PW       = ptr_w(DEPTH);
  localparam int             CW       = cnt_w(DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam bit             OVR      = (ovf_mode_e'(MODE) == OVF_OVERWRITE);

  logic [PCKG-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf, r_udf;

  logic w_empty, w_full, w_wr, w_rd, w_ovf_evt, w_udf_evt;

  // Depth need not be a power of two, so wrap by compare rather than truncation.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CNT_FULL);
    w_wr      = push && (!w_full || pop || OVR);
    w_rd      = (pop && !w_empty) || (push && w_full && OVR);
    w_ovf_evt = push && w_full && !pop;
    w_udf_evt = pop && w_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= ptr_inc(r_wptr);
      if (w_rd) r_rptr <= ptr_inc(r_rptr);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
      // A fresh event in the clearing cycle keeps the flag set.
      r_ovf <= w_ovf_evt || (r_ovf && !err_clr);
      r_udf <= w_udf_evt || (r_udf && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset) r_mem[r_wptr] <= D_push;
  end

  assign D_pop = w_empty ? '0 : r_mem[r_rptr];
  assign pndng = !w_empty;
  assign full  = w_full;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// File: rtl/drvr_fifo_bank.sv
// Bank of independent per-driver FIFOs feeding the bus arbiter.
// Channels share only the clock and reset.
module drvr_fifo_bank
  import drvr_fifo_pkg::*;
#(
  parameter int DRIVERS = 4,
  parameter int PCKG    = 16,
  parameter int DEPTH   = 8,
  parameter int MODE    = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DRIVERS-1:0]                    push,
  input  logic [DRIVERS-1:0][PCKG-1:0]          D_push,
  input  logic [DRIVERS-1:0]                    pop,
  output logic [DRIVERS-1:0][PCKG-1:0]          D_pop,
  output logic [DRIVERS-1:0]                    pndng,
  output logic [DRIVERS-1:0]                    full,
  output logic [DRIVERS-1:0][cnt_w(DEPTH)-1:0]  count,
  output logic [DRIVERS-1:0]                    ovf,
  output logic [DRIVERS-1:0]                    udf,
  input  logic [DRIVERS-1:0]                    err_clr
);

  for (genvar g = 0; g < DRIVERS; g++) begin : g_chnl
    drvr_fifo_chnl #(
      .PCKG  (PCKG),
      .DEPTH (DEPTH),
      .MODE  (MODE)
    ) u_chnl (
      .clk     (clk),
      .reset   (reset),
      .push    (push[g]),
      .D_push  (D_push[g]),
      .pop     (pop[g]),
      .err_clr (err_clr[g]),
      .D_pop   (D_pop[g]),
      .pndng   (pndng[g]),
      .full    (full[g]),
      .count   (count[g]),
      .ovf     (ovf[g]),
      .udf     (udf[g])
    );
  end

endmodule

// File: tb/tb_drvr_fifo_bank.sv
// Three bank configurations (depth 8 drop, depth 8 overwrite, depth 5 drop) share one
// stimulus stream and are compared every cycle against queue-based reference models.
module tb_drvr_fifo_bank;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        push, pop, clr;
  logic [3:0][15:0]  dpush;

  logic [3:0][15:0]  dp0, dp1, dp2;
  logic [3:0]        pn0, pn1, pn2, fu0, fu1, fu2, ov0, ov1, ov2, ud0, ud1, ud2;
  logic [3:0][3:0]   cn0, cn1;
  logic [3:0][2:0]   cn2;

  always #5 clk = ~clk;

  drvr_fifo_bank #(.DRIVERS(4), .PCKG(16), .DEPTH(8), .MODE(0)) u0 (
    .clk(clk), .reset(rst), .push(push), .D_push(dpush), .pop(pop), .D_pop(dp0),
    .pndng(pn0), .full(fu0), .count(cn0), .ovf(ov0), .udf(ud0), .err_clr(clr));
  drvr_fifo_bank #(.DRIVERS(4), .PCKG(16), .DEPTH(8), .MODE(1)) u1 (
    .clk(clk), .reset(rst), .push(push), .D_push(dpush), .pop(pop), .D_pop(dp1),
    .pndng(pn1), .full(fu1), .count(cn1), .ovf(ov1), .udf(ud1), .err_clr(clr));
  drvr_fifo_bank #(.DRIVERS(4), .PCKG(16), .DEPTH(5), .MODE(0)) u2 (
    .clk(clk), .reset(rst), .push(push), .D_push(dpush), .pop(pop), .D_pop(dp2),
    .pndng(pn2), .full(fu2), .count(cn2), .ovf(ov2), .udf(ud2), .err_clr(clr));

  // Reference model: one queue per channel per configuration plus sticky flags.
  logic [15:0] mq [3][4][$];
  bit          m_ovf [3][4];
  bit          m_udf [3][4];
  int          depth_of [3] = '{8, 8, 5};
  int          mode_of  [3] = '{0, 1, 0};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        bit eo, eu;
        int n;
        eo = 1'b0;
        eu = 1'b0;
        n  = mq[d][c].size();
        if (rst) begin
          mq[d][c].delete();
          m_ovf[d][c] = 1'b0;
          m_udf[d][c] = 1'b0;
        end else begin
          if (push[c] && pop[c]) begin
            if (n == 0) eu = 1'b1;
            else void'(mq[d][c].pop_front());
            mq[d][c].push_back(dpush[c]);
          end else if (push[c]) begin
            if (n == depth_of[d]) begin
              eo = 1'b1;
              if (mode_of[d] == 1) begin
                void'(mq[d][c].pop_front());
                mq[d][c].push_back(dpush[c]);
              end
            end else begin
              mq[d][c].push_back(dpush[c]);
            end
          end else if (pop[c]) begin
            if (n == 0) eu = 1'b1;
            else void'(mq[d][c].pop_front());
          end
          m_ovf[d][c] = eo | (m_ovf[d][c] & ~clr[c]);
          m_udf[d][c] = eu | (m_udf[d][c] & ~clr[c]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] o_cnt, o_dat, e_dat;
        logic        o_p, o_f, o_o, o_u;
        int          n;
        case (d)
          0: begin o_cnt = 32'(cn0[c]); o_dat = 32'(dp0[c]); o_p = pn0[c]; o_f = fu0[c]; o_o = ov0[c]; o_u = ud0[c]; end
          1: begin o_cnt = 32'(cn1[c]); o_dat = 32'(dp1[c]); o_p = pn1[c]; o_f = fu1[c]; o_o = ov1[c]; o_u = ud1[c]; end
          default: begin o_cnt = 32'(cn2[c]); o_dat = 32'(dp2[c]); o_p = pn2[c]; o_f = fu2[c]; o_o = ov2[c]; o_u = ud2[c]; end
        endcase
        n     = mq[d][c].size();
        e_dat = (n != 0) ? 32'(mq[d][c][0]) : 32'h0;
        chk($sformatf("u%0d.ch%0d.count", d, c), o_cnt, 32'(n));
        chk($sformatf("u%0d.ch%0d.D_pop", d, c), o_dat, e_dat);
        chk($sformatf("u%0d.ch%0d.pndng", d, c), 32'(o_p), 32'(n != 0));
        chk($sformatf("u%0d.ch%0d.full", d, c),  32'(o_f), 32'(n == depth_of[d]));
        chk($sformatf("u%0d.ch%0d.ovf", d, c),   32'(o_o), 32'(m_ovf[d][c]));
        chk($sformatf("u%0d.ch%0d.udf", d, c),   32'(o_u), 32'(m_udf[d][c]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst  = 1'b0;
    push = '0;
    pop  = '0;
    clr  = '0;
  endtask

  initial begin
    idle();
    dpush = '0;
    rst   = 1'b1;
    push  = 4'hF;
    pop   = 4'hF;
    cycle();
    cycle();

    // Fill channel 0 with 0x17..0x1E.
    for (int i = 0; i < 8; i++) begin
      idle(); push[0] = 1'b1; dpush[0] = 16'(16'h17 + i); cycle();
    end
    // Push onto a full channel: dropped in u0, overwrites oldest in u1.
    idle(); push[0] = 1'b1; dpush[0] = 16'h00AA; cycle();
    // Drain plus one extra pop on empty.
    for (int i = 0; i < 9; i++) begin
      idle(); pop[0] = 1'b1; cycle();
    end
    // err_clr with a fresh underflow: set wins; then err_clr alone clears.
    idle(); pop[0] = 1'b1; clr[0] = 1'b1; cycle();
    idle(); clr = 4'hF; cycle();
    idle(); cycle();

    // Steady state at occupancy 3 on channel 1: pointers wrap in the depth-5 bank.
    for (int i = 0; i < 20; i++) begin
      idle(); push[1] = 1'b1; dpush[1] = 16'(16'h100 + i);
      if (i >= 3) pop[1] = 1'b1;
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); pop[1] = 1'b1; cycle();
    end

    // Randomized traffic: push-heavy first half, pop-heavy second half.
    for (int i = 0; i < 400; i++) begin
      idle();
      if (i < 200) begin
        push = 4'($urandom) | 4'($urandom);
        pop  = 4'($urandom) & 4'($urandom);
      end else begin
        push = 4'($urandom) & 4'($urandom);
        pop  = 4'($urandom) | 4'($urandom);
      end
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < 4; c++) dpush[c] = 16'($urandom);
      cycle();
    end

    // Distinct streams on all channels, then reset with channel 2 at count 5.
    idle(); rst = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      idle(); push = 4'hF;
      for (int c = 0; c < 4; c++) dpush[c] = 16'((c + 1) * 16'h1000 + i);
      cycle();
    end
    idle(); rst = 1'b1; push = 4'hF; pop = 4'hF; cycle();
    idle(); push[3] = 1'b1; dpush[3] = 16'h5A5A; cycle();
    idle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/drvr_fifo_bank.md
# drvr_fifo_bank

Bank of `DRIVERS` independent first-word-fall-through FIFOs that buffers packets between each bus driver agent and the bus generator/arbiter. One FIFO per driver. Exposes `pndng`/`pop`/`D_pop` toward the arbiter, plus occupancy and error status. It replaces the single unparametrised software FIFO with synthesizable, per-channel buffering that has configurable depth and width, a selectable overflow policy, and sticky error flags.

## Interface
Parameters:
- `DRIVERS`, 4: number of channels (≥1)
- `PCKG`, 16: packet width in bits (≥1)
- `DEPTH`, 8: entries per channel (≥2; need not be a power of two)
- `MODE`, 0: overflow policy. 0 = drop newest, 1 = overwrite oldest.

Ports (direction, width, meaning):
- `clk`: in, 1. Sole clock; all state updates on the rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `push`: in, `[DRIVERS-1:0]`. Write request per channel.
- `D_push`: in, `[DRIVERS-1:0][PCKG-1:0]`. Write data per channel.
- `pop`: in, `[DRIVERS-1:0]`. Arbiter consumes the head entry.
- `D_pop`: out, `[DRIVERS-1:0][PCKG-1:0]`. Head entry; 0 when the channel is empty.
- `pndng`: out, `[DRIVERS-1:0]`. Channel holds ≥1 entry.
- `full`: out, `[DRIVERS-1:0]`. Channel holds `DEPTH` entries.
- `count`: out, `[DRIVERS-1:0][$clog2(DEPTH+1)-1:0]`. Occupancy.
- `ovf`: out, `[DRIVERS-1:0]`. Sticky overflow flag.
- `udf`: out, `[DRIVERS-1:0]`. Sticky underflow flag.
- `err_clr`: in, `[DRIVERS-1:0]`. Clears `ovf`/`udf` of that channel.

## Operation
- Channels are fully independent; no shared state.
- Each channel has storage of `DEPTH`×`PCKG`, a write pointer, a read pointer and `count`.
- Pointers increment modulo `DEPTH`: value `DEPTH-1` wraps to 0. Explicit compare, not bit truncation.
- Push, not full: write `D_push` at the write pointer, advance the write pointer, `count`+1.
- Pop, not empty: advance the read pointer, `count`−1.
- Push and pop in the same cycle, 0 < `count` < `DEPTH`: both take effect; `count` is unchanged.
- Push and pop in the same cycle, full: both take effect; `count` stays `DEPTH`; `ovf` is not set.
- Push and pop in the same cycle, empty: push is accepted and pop is ignored; `udf` is set; `count` becomes 1.
- Pop alone when empty: ignored; `udf` set; `D_pop` stays 0.
- Push alone when full, `MODE`=0: data discarded; pointers and `count` unchanged; `ovf` set.
- Push alone when full, `MODE`=1: the oldest entry is discarded (read pointer advances) and the new data is written; `count` stays `DEPTH`; `ovf` set.
- `err_clr` clears both sticky flags next cycle. If a new overflow or underflow event occurs in the same cycle, set wins.
- `pndng` = (`count` ≠ 0); `full` = (`count` == `DEPTH`). Both are derived from registered `count` only.

## Timing
- Reset values: `count`=0, pointers=0, `pndng`=0, `full`=0, `ovf`=0, `udf`=0, `D_pop`=0. Storage is not reset.
- A reset asserted mid-operation empties every channel in one cycle. `push`/`pop` in the reset cycle are ignored.
- Push in cycle N into an empty channel: `pndng`=1 and `D_pop`=data in cycle N+1 (one-cycle latency, FWFT).
- Pop in cycle N: the next entry appears on `D_pop` in N+1. If the channel is now empty, `pndng`=0 and `D_pop`=0 in N+1.
- `D_pop` is a mux of registered storage/pointer. No combinational path from `push`/`pop` to any output.
- Throughput: one push and one pop per channel per cycle.

## Structure
- Package `drvr_fifo_pkg`:
  - `typedef enum logic {OVF_DROP=0, OVF_OVERWRITE=1} ovf_mode_e`
  - pointer/count width helper functions.
- Sub-module `drvr_fifo_chnl`: a single channel with scalar ports, parametrised by `PCKG`, `DEPTH`, `MODE`.
- `drvr_fifo_bank`: a generate loop instancing `DRIVERS` copies of `drvr_fifo_chnl`.

## Test plan
- Reset, then push 0x17..0x1E into channel 0 on consecutive cycles (`DEPTH`=8):
  - `count` steps 1..8 and `full` rises after the 8th push.
  - 8 pops return 0x17..0x1E in order; `pndng` falls one cycle after the last pop.
- Full channel, `MODE`=0, push 0xAA: `count` stays 8, `ovf`=1, and the pop sequence is unchanged (no 0xAA).
- Full channel, `MODE`=1, push 0xAA: `ovf`=1; pops return 0x18..0x1E then 0xAA.
- `DEPTH`=5, 20 pushes interleaved with pops at `count`=3:
  - simultaneous push+pop keeps `count`=3;
  - pointers wrap 4→0;
  - data order is preserved.
- Empty channel, pop: `udf`=1 and `D_pop`=0. Then `err_clr` together with another empty pop leaves `udf`=1 (set wins); `err_clr` alone clears it next cycle.
- All 4 channels pushing distinct streams, `reset` asserted while channel 2 has `count`=5: every `count`, `pndng` and flag is 0 next cycle, and a new push after reset reads back correctly.
